// File: rtl/acc_multiblock_ctrl_if.sv
// Bus bundle for acc_multiblock_ctrl: MMIO listen port, arbiter read/write ports and the
// message-scheduler / compressor control lines. master = controller side, slave = environment.
interface acc_multiblock_ctrl_if #(
  parameter int unsigned LISTEN_ADDR_W = 16,
  parameter int unsigned LISTEN_DATA_W = 32,
  parameter int unsigned RD_ADDR_W     = 16,
  parameter int unsigned RD_DATA_W     = 512,
  parameter int unsigned WR_ADDR_W     = 16,
  parameter int unsigned WR_DATA_W     = 32
);
  logic                     mem_listen_en;
  logic [LISTEN_ADDR_W-1:0] mem_listen_addr;
  logic [LISTEN_DATA_W-1:0] mem_listen_data;
  logic                     mem_acc_read_en;
  logic [RD_ADDR_W-1:0]     mem_acc_read_addr;
  logic [RD_DATA_W-1:0]     mem_acc_read_data;
  logic                     mem_acc_read_data_valid;
  logic                     mem_acc_write_en;
  logic [WR_ADDR_W-1:0]     mem_acc_write_addr;
  logic [WR_DATA_W-1:0]     mem_acc_write_data;
  logic                     mem_acc_write_done;
  logic [511:0]             ms_block;
  logic                     ms_init;
  logic                     ms_enable;
  logic                     cm_init;
  logic                     cm_enable;
  logic                     cm_chain;
  logic [255:0]             cm_out;

  modport master (
    input  mem_listen_en, mem_listen_addr, mem_listen_data,
    input  mem_acc_read_data, mem_acc_read_data_valid, mem_acc_write_done, cm_out,
    output mem_acc_read_en, mem_acc_read_addr,
    output mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data,
    output ms_block, ms_init, ms_enable, cm_init, cm_enable, cm_chain
  );

  modport slave (
    output mem_listen_en, mem_listen_addr, mem_listen_data,
    output mem_acc_read_data, mem_acc_read_data_valid, mem_acc_write_done, cm_out,
    input  mem_acc_read_en, mem_acc_read_addr,
    input  mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data,
    input  ms_block, ms_init, ms_enable, cm_init, cm_enable, cm_chain
  );
endinterface

// File: rtl/acc_multiblock_ctrl.sv
// Multi-block SHA-256 accelerator controller: MMIO start, N block fetches, chained compressions,
// digest write-back. Optional ACC_DOUBLE_HASH_EN adds a second pass hashing the first digest.
module acc_multiblock_ctrl #(
  parameter int unsigned LISTEN_ADDR_W  = 16,
  parameter int unsigned LISTEN_DATA_W  = 32,
  parameter int unsigned RD_ADDR_W      = 16,
  parameter int unsigned RD_DATA_W      = 512,
  parameter int unsigned WR_ADDR_W      = 16,
  parameter int unsigned WR_DATA_W      = 32,
  parameter int unsigned HCB_MSG_ADDR   = 32'h1008,
  parameter int unsigned BLOCK_STRIDE   = 32'h0040,
  parameter int unsigned ACB_START_ADDR = 32'h5000,
  parameter int unsigned ACB_H0_ADDR    = 32'h5008,
  parameter int unsigned WORD_STRIDE    = 32'h0004,
  parameter int unsigned MAX_BLOCKS     = 8,
  parameter int unsigned HASH_CYCLES    = 64
) (
  input logic                   clk,
  input logic                   rst,
  acc_multiblock_ctrl_if.master bus
);
  localparam int unsigned NUM_WORDS = 256 / WR_DATA_W;
  localparam int unsigned WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CNT_W     = (HASH_CYCLES > 1) ? $clog2(HASH_CYCLES) : 1;

  typedef enum logic [3:0] {
    StIdle, StBusy, StRead, StInit, StHash, StWrite, StDone, StErr
`ifdef ACC_DOUBLE_HASH_EN
    , StPad
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         blk_q, blk_d;
  logic [7:0]         n_q, n_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [511:0]       block_q, block_d;
`ifdef ACC_DOUBLE_HASH_EN
  logic               second_q, second_d;
`endif

  logic       start;
  logic [7:0] start_n;
  logic       chain;

  assign start   = bus.mem_listen_en && (bus.mem_listen_addr == LISTEN_ADDR_W'(ACB_START_ADDR)) &&
                   bus.mem_listen_data[0];
  assign start_n = bus.mem_listen_data[15:8];
`ifdef ACC_DOUBLE_HASH_EN
  assign chain   = (blk_q != 8'd0) && !second_q;
`else
  assign chain   = (blk_q != 8'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      blk_q    <= '0;
      n_q      <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      block_q  <= '0;
`ifdef ACC_DOUBLE_HASH_EN
      second_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      n_q      <= n_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
`ifdef ACC_DOUBLE_HASH_EN
      second_q <= second_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    n_d      = n_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    block_d  = block_q;
`ifdef ACC_DOUBLE_HASH_EN
    second_d = second_q;
`endif
    bus.mem_acc_read_en    = 1'b0;
    bus.mem_acc_read_addr  = '0;
    bus.mem_acc_write_en   = 1'b0;
    bus.mem_acc_write_addr = '0;
    bus.mem_acc_write_data = '0;
    bus.ms_block           = block_q;
    bus.ms_init            = 1'b0;
    bus.ms_enable          = 1'b0;
    bus.cm_init            = 1'b0;
    bus.cm_enable          = 1'b0;
    bus.cm_chain           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d   = start_n;
          blk_d = '0;
`ifdef ACC_DOUBLE_HASH_EN
          second_d = 1'b0;
`endif
          if (start_n == 8'd0 || 32'(start_n) > MAX_BLOCKS) state_d = StErr;
          else                                               state_d = StBusy;
        end
      end
      StBusy: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = WR_ADDR_W'(ACB_START_ADDR);
        bus.mem_acc_write_data = WR_DATA_W'(32'h5);
        if (bus.mem_acc_write_done) state_d = StRead;
      end
      StRead: begin
        bus.mem_acc_read_en   = 1'b1;
        bus.mem_acc_read_addr = RD_ADDR_W'(HCB_MSG_ADDR + 32'(blk_q) * BLOCK_STRIDE);
        if (bus.mem_acc_read_data_valid) begin
          block_d = 512'(bus.mem_acc_read_data);
          state_d = StInit;
        end
      end
      StInit: begin
        bus.ms_init  = 1'b1;
        bus.cm_init  = 1'b1;
        bus.cm_chain = chain;
        cnt_d        = '0;
        state_d      = StHash;
      end
      StHash: begin
        bus.ms_enable = 1'b1;
        bus.cm_enable = 1'b1;
        if (cnt_q == CNT_W'(HASH_CYCLES - 1)) begin
          if ((9'(blk_q) + 9'd1) < 9'(n_q)) begin
            blk_d   = blk_q + 8'd1;
            state_d = StRead;
          end else begin
`ifdef ACC_DOUBLE_HASH_EN
            if (!second_q) begin
              state_d = StPad;
            end else begin
              word_d  = '0;
              state_d = StWrite;
            end
`else
            word_d  = '0;
            state_d = StWrite;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef ACC_DOUBLE_HASH_EN
      // Second pass: the 256-bit digest as a single padded message block.
      StPad: begin
        block_d  = {bus.cm_out, 1'b1, 191'b0, 64'd256};
        second_d = 1'b1;
        state_d  = StInit;
      end
`endif
      StWrite: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = WR_ADDR_W'(ACB_H0_ADDR + 32'(word_q) * WORD_STRIDE);
        bus.mem_acc_write_data = bus.cm_out[32'(word_q) * WR_DATA_W +: WR_DATA_W];
        if (bus.mem_acc_write_done) begin
          if (word_q == WORD_W'(NUM_WORDS - 1)) state_d = StDone;
          else                                  word_d  = word_q + WORD_W'(1);
        end
      end
      StDone: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = WR_ADDR_W'(ACB_START_ADDR);
        bus.mem_acc_write_data = WR_DATA_W'(32'h2);
        if (bus.mem_acc_write_done) state_d = StIdle;
      end
      StErr: begin
        bus.mem_acc_write_en   = 1'b1;
        bus.mem_acc_write_addr = WR_ADDR_W'(ACB_START_ADDR);
        bus.mem_acc_write_data = WR_DATA_W'(32'hA);
        if (bus.mem_acc_write_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end
endmodule
